jtag_dma_controller: RTL and testbench
======================================

// Module: jtag_dma_controller
// PURPOSE
//  Bus-master sequencer behind the JTAG chain-1 command register. Starts one DMA burst per launch toggle from the
//  JTCK domain, moving words between the JTAG-side word buffer and the system bus, and reports busy/error back to
//  the chain. Clock/reset: clock, reset; reset is asynchronous and active-high; all logic runs on clock.
// PARAMETERS
//  BUF_ADDR_W      5     buffer address width; max burst = 2**BUF_ADDR_W words
//  TIMEOUT_CYCLES  1024  watchdog limit in clock cycles (used only with JTAG_DMA_TIMEOUT_EN)
// PORTS
//  clock                  in   1   system clock
//  reset                  in   1   asynchronous active-high reset
//  start_toggle_in        in   1   JTCK-domain launch; each level change = one request
//  read_not_write_in      in   1   1 = bus->buffer, 0 = buffer->bus (quasi-static, sampled at launch)
//  address_in             in   32  bus start address (quasi-static, sampled at launch)
//  burst_size_in          in   8   words-1 (quasi-static, sampled at launch)
//  byte_enables_in        in   4   byte enables for every word (quasi-static, sampled at launch)
//  buffer_address_out     out  BUF_ADDR_W  buffer word address; synchronous read, 1-cycle latency
//  buffer_data_in         in   32  buffer read data
//  buffer_data_out        out  32  buffer write data
//  buffer_write_enable_out out 1   buffer write strobe
//  request_out            out  1   bus request
//  grant_in               in   1   bus grant
//  begin_transaction_out  out  1   1-cycle transaction start
//  address_data_out       out  32  address in begin cycle, write data otherwise
//  byte_enables_out       out  4   byte enables, valid in begin cycle
//  burst_size_out         out  8   words-1, valid in begin cycle
//  read_n_write_out       out  1   direction, valid in begin cycle
//  data_valid_out         out  1   write word valid
//  end_transaction_out    out  1   1-cycle transaction end (write or abort)
//  address_data_in        in   32  read data
//  data_valid_in          in   1   read word valid
//  busy_in                in   1   slave stall; write word not accepted while high
//  end_transaction_in     in   1   slave ends read transaction
//  error_in               in   1   bus error
//  busy_out               out  1   high from launch detect until return to IDLE (to chain DMA_busy)
//  error_out              out  1   sticky error flag; cleared at next launch
//  done_toggle_out        out  1   toggles once per completed or aborted transfer
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, synchroniser flops 0.
//  - Launch: start_toggle_in goes through a 2-flop synchroniser plus edge register; launch = sync XOR prev.
//    IDLE->REQUEST the cycle after launch. Latches address, burst (clamped to 2**BUF_ADDR_W-1), direction and BE.
//    busy_out rises in the same cycle; error_out clears.
//  - Launches while busy_out = 1 are ignored; the edge register still tracks, so there is no queued replay.
//  - REQUEST: request_out = 1 until grant_in = 1 -> INIT. INIT: begin_transaction_out = 1 for one cycle, with the
//    address/BE/burst/direction driven. Writes: buffer_address_out = 0 here -> WRITE. Reads -> READ.
//  - WRITE: data_valid_out = 1, address_data_out = buffer_data_in. Word accepted = data_valid_out & !busy_in.
//    buffer_address_out = ptr+1 on accept, else ptr, giving 1 word/cycle with no bubbles.
//    After the last accept: END (end_transaction_out = 1 for 1 cycle) -> IDLE.
//  - READ: each data_valid_in writes address_data_in at ptr (buffer_write_enable_out = 1), then ptr++.
//    Words beyond burst+1 are dropped, and ptr never wraps. end_transaction_in -> IDLE, even with fewer words.
//  - error_in in INIT/WRITE/READ: error_out = 1. If the slave did not end, END (1-cycle end_transaction_out) -> IDLE.
//    end_transaction_in together with error_in: error wins, no extra end cycle.
//  - done_toggle_out toggles on each entry to IDLE from a non-IDLE state. request_out drops in the cycle after INIT.
//  - Reset mid-transfer: immediate return to IDLE with all outputs 0; no end_transaction_out is issued.
// CONFIGURATION
//  JTAG_DMA_TIMEOUT_EN defined: a counter resets on each state change, accepted word and received word.
//    Reaching TIMEOUT_CYCLES outside IDLE sets error_out and goes to END (or straight to IDLE from REQUEST).
//  Not defined: no counter; the controller waits indefinitely for grant/data.
// TESTING
//  1. Write burst_size_in=2, address_in=0x55555555, buffer={A,B,C}, busy_in=0 -> begin with 0x55555555/burst 2.
//     Then data_valid_out on A,B,C in 3 consecutive cycles, one end_transaction_out, done toggles, busy_out falls.
//  2. Same write with busy_in high 2 cycles on word B -> B held stable on address_data_out, no duplicate or skip.
//  3. Read burst 3, slave returns 4 words then end_transaction_in -> buffer[0..3] written in order, error_out=0.
//  4. error_in during the 2nd write word -> error_out=1, single end_transaction_out, IDLE. Next launch clears it.
//  5. Second toggle while busy -> ignored, exactly one transaction. grant_in held low >TIMEOUT_CYCLES with
//     JTAG_DMA_TIMEOUT_EN -> error_out=1, IDLE.
//  6. Reset asserted in WRITE -> all outputs 0 within the reset cycle. A new launch then runs cleanly from word 0.

Source files
------------

// File: rtl/jtag_dma_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : jtag_dma_controller
// Description : Bus-master DMA sequencer behind the JTAG chain-1 command
//               register. One burst per launch toggle, buffer <-> system bus.
//               Optional watchdog enabled by defining JTAG_DMA_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_dma_controller #(
  parameter int BUF_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_toggle_in,
  input  logic                  read_not_write_in,
  input  logic [31:0]           address_in,
  input  logic [7:0]            burst_size_in,
  input  logic [3:0]            byte_enables_in,
  output logic [BUF_ADDR_W-1:0] buffer_address_out,
  input  logic [31:0]           buffer_data_in,
  output logic [31:0]           buffer_data_out,
  output logic                  buffer_write_enable_out,
  output logic                  request_out,
  input  logic                  grant_in,
  output logic                  begin_transaction_out,
  output logic [31:0]           address_data_out,
  output logic [3:0]            byte_enables_out,
  output logic [7:0]            burst_size_out,
  output logic                  read_n_write_out,
  output logic                  data_valid_out,
  output logic                  end_transaction_out,
  input  logic [31:0]           address_data_in,
  input  logic                  data_valid_in,
  input  logic                  busy_in,
  input  logic                  end_transaction_in,
  input  logic                  error_in,
  output logic                  busy_out,
  output logic                  error_out,
  output logic                  done_toggle_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_INIT    = 3'd2,
    S_WRITE   = 3'd3,
    S_READ    = 3'd4,
    S_END     = 3'd5
  } state_t;

  localparam int c_MAX_BURST = (1 << BUF_ADDR_W) - 1;

  state_t                r_state;
  state_t                w_next;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_prev;
  logic [31:0]           r_addr;
  logic [7:0]            r_burst;
  logic                  r_rnw;
  logic [3:0]            r_be;
  logic [BUF_ADDR_W-1:0] r_ptr;
  logic                  r_full;
  logic                  r_error;
  logic                  r_done;

  logic                  w_launch;
  logic [7:0]            w_burst_clamped;
  logic [BUF_ADDR_W-1:0] w_last_idx;
  logic                  w_set_error;
  logic                  w_accept;
  logic                  w_rd_store;
  logic                  w_timeout;

  assign w_launch   = r_sync2 ^ r_prev;
  assign w_last_idx = BUF_ADDR_W'(r_burst);

  // The buffer bounds the burst; a larger request is cut to the buffer depth.
  generate
    if (BUF_ADDR_W < 8) begin : g_clamp
      assign w_burst_clamped = (burst_size_in > 8'(c_MAX_BURST)) ? 8'(c_MAX_BURST) : burst_size_in;
    end else begin : g_noclamp
      assign w_burst_clamped = burst_size_in;
    end
  endgenerate

`ifdef JTAG_DMA_TIMEOUT_EN
  localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TMR_W-1:0] r_timer;
  logic               w_timer_clear;

  // Any sign of progress restarts the watchdog.
  assign w_timer_clear = (r_state == S_IDLE) || (w_next != r_state) || w_accept ||
                         ((r_state == S_READ) && data_valid_in);
  assign w_timeout     = (r_state != S_IDLE) && (r_timer >= c_TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_timer_clear) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end
`else
  // Watchdog compiled out: the controller waits indefinitely for the bus.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_next                  = r_state;
    w_set_error             = 1'b0;
    w_accept                = 1'b0;
    w_rd_store              = 1'b0;
    request_out             = 1'b0;
    begin_transaction_out   = 1'b0;
    address_data_out        = '0;
    byte_enables_out        = '0;
    burst_size_out          = '0;
    read_n_write_out        = 1'b0;
    data_valid_out          = 1'b0;
    end_transaction_out     = 1'b0;
    buffer_address_out      = '0;
    buffer_data_out         = '0;
    buffer_write_enable_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) w_next = S_REQUEST;
      end
      S_REQUEST: begin
        request_out = 1'b1;
        if (w_timeout) begin
          w_set_error = 1'b1;
          w_next      = S_IDLE;
        end else if (grant_in) begin
          w_next = S_INIT;
        end
      end
      S_INIT: begin
        // Buffer address 0 is presented here so word 0 arrives on WRITE entry.
        request_out           = 1'b1;
        begin_transaction_out = 1'b1;
        address_data_out      = r_addr;
        byte_enables_out      = r_be;
        burst_size_out        = r_burst;
        read_n_write_out      = r_rnw;
        if (error_in) begin
          w_set_error = 1'b1;
          w_next      = S_END;
        end else begin
          w_next = r_rnw ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        data_valid_out     = 1'b1;
        address_data_out   = buffer_data_in;
        buffer_address_out = r_ptr;
        if (error_in) begin
          w_set_error = 1'b1;
          w_next      = S_END;
        end else if (!busy_in) begin
          // Prefetch the next word so accepted words stream without bubbles.
          w_accept           = 1'b1;
          buffer_address_out = r_ptr + 1'b1;
          if (r_ptr == w_last_idx) w_next = S_END;
        end else if (w_timeout) begin
          w_set_error = 1'b1;
          w_next      = S_END;
        end
      end
      S_READ: begin
        buffer_address_out = r_ptr;
        buffer_data_out    = address_data_in;
        if (error_in) begin
          w_set_error = 1'b1;
          w_next      = end_transaction_in ? S_IDLE : S_END;
        end else begin
          if (data_valid_in && !r_full) begin
            w_rd_store              = 1'b1;
            buffer_write_enable_out = 1'b1;
          end
          if (end_transaction_in) begin
            w_next = S_IDLE;
          end else if (w_timeout) begin
            w_set_error = 1'b1;
            w_next      = S_END;
          end
        end
      end
      S_END: begin
        end_transaction_out = 1'b1;
        w_next              = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_addr  <= '0;
      r_burst <= '0;
      r_rnw   <= 1'b0;
      r_be    <= '0;
      r_ptr   <= '0;
      r_full  <= 1'b0;
      r_error <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_sync1 <= start_toggle_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_launch) begin
        r_addr  <= address_in;
        r_burst <= w_burst_clamped;
        r_rnw   <= read_not_write_in;
        r_be    <= byte_enables_in;
        r_error <= 1'b0;
      end else if (w_set_error) begin
        r_error <= 1'b1;
      end
      if (r_state == S_INIT) begin
        r_ptr  <= '0;
        r_full <= 1'b0;
      end else if (w_accept) begin
        r_ptr <= r_ptr + 1'b1;
      end else if (w_rd_store) begin
        // Hold the pointer at the last slot so surplus read words are dropped.
        if (r_ptr == w_last_idx) r_full <= 1'b1;
        else                     r_ptr  <= r_ptr + 1'b1;
      end
      if ((r_state != S_IDLE) && (w_next == S_IDLE)) r_done <= ~r_done;
    end
  end

  assign busy_out        = (r_state != S_IDLE);
  assign error_out       = r_error;
  assign done_toggle_out = r_done;

endmodule
`default_nettype wire

// File: tb/tb_jtag_dma_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_jtag_dma_controller
// Description : Directed self-checking bench for jtag_dma_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_dma_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_toggle_in;
  logic        read_not_write_in;
  logic [31:0] address_in;
  logic [7:0]  burst_size_in;
  logic [3:0]  byte_enables_in;
  logic [4:0]  buffer_address_out;
  logic [31:0] buffer_data_in;
  logic [31:0] buffer_data_out;
  logic        buffer_write_enable_out;
  logic        request_out;
  logic        grant_in;
  logic        begin_transaction_out;
  logic [31:0] address_data_out;
  logic [3:0]  byte_enables_out;
  logic [7:0]  burst_size_out;
  logic        read_n_write_out;
  logic        data_valid_out;
  logic        end_transaction_out;
  logic [31:0] address_data_in;
  logic        data_valid_in;
  logic        busy_in;
  logic        end_transaction_in;
  logic        error_in;
  logic        busy_out;
  logic        error_out;
  logic        done_toggle_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:31];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;

  logic [31:0] q_words[$];
  logic [31:0] q_stall[$];
  int          n_begin, n_end, n_valid, n_we, first_acc, last_acc;
  logic [31:0] b_addr;
  logic [7:0]  b_burst;
  logic        b_rnw;
  logic [3:0]  b_be;
  logic        exp_done;

  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;

  jtag_dma_controller dut (
    .clock                   (clock),
    .reset                   (reset),
    .start_toggle_in         (start_toggle_in),
    .read_not_write_in       (read_not_write_in),
    .address_in              (address_in),
    .burst_size_in           (burst_size_in),
    .byte_enables_in         (byte_enables_in),
    .buffer_address_out      (buffer_address_out),
    .buffer_data_in          (buffer_data_in),
    .buffer_data_out         (buffer_data_out),
    .buffer_write_enable_out (buffer_write_enable_out),
    .request_out             (request_out),
    .grant_in                (grant_in),
    .begin_transaction_out   (begin_transaction_out),
    .address_data_out        (address_data_out),
    .byte_enables_out        (byte_enables_out),
    .burst_size_out          (burst_size_out),
    .read_n_write_out        (read_n_write_out),
    .data_valid_out          (data_valid_out),
    .end_transaction_out     (end_transaction_out),
    .address_data_in         (address_data_in),
    .data_valid_in           (data_valid_in),
    .busy_in                 (busy_in),
    .end_transaction_in      (end_transaction_in),
    .error_in                (error_in),
    .busy_out                (busy_out),
    .error_out               (error_out),
    .done_toggle_out         (done_toggle_out)
  );

  always #5 clock = ~clock;

  // Word buffer: synchronous read with one cycle of latency.
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (buffer_write_enable_out) mem[buffer_address_out] <= buffer_data_out;
    buffer_data_in <= mem[buffer_address_out];
  end

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = 5'(a); pre_data = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic launch(input logic rnw, input logic [31:0] addr, input logic [7:0] burst, input logic [3:0] be);
    bit seen = 0;
    @(negedge clock);
    read_not_write_in = rnw; address_in = addr; burst_size_in = burst; byte_enables_in = be;
    start_toggle_in = ~start_toggle_in;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clock); #1;
      if (busy_out) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL launch_busy: busy_out=%b expected 1", busy_out);
    end
  endtask

  task automatic run_write(input int stall_word, input int stall_cycles, input int err_word);
    int stall_left = stall_cycles;
    int acc = 0;
    bit fin = 0;
    q_words.delete(); q_stall.delete();
    n_begin = 0; n_end = 0; n_valid = 0; first_acc = -1; last_acc = -1;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clock);
      busy_in = 1'b0; error_in = 1'b0;
      #1;
      if (!busy_out) fin = 1;
      else begin
        if (begin_transaction_out) begin
          n_begin++; b_addr = address_data_out; b_burst = burst_size_out;
          b_rnw = read_n_write_out; b_be = byte_enables_out;
        end
        if (end_transaction_out) n_end++;
        if (data_valid_out) begin
          n_valid++;
          if (acc == err_word) error_in = 1'b1;
          else if (acc == stall_word && stall_left > 0) begin
            busy_in = 1'b1; stall_left--; q_stall.push_back(address_data_out);
          end else begin
            q_words.push_back(address_data_out);
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc; acc++;
          end
        end
      end
    end
    n_checks++;
    if (!fin) begin
      n_errors++;
      $display("FAIL write_complete: busy_out=%b expected 0 within 200 cycles", busy_out);
    end
  endtask

  task automatic run_read(input int nwords, input logic [31:0] base);
    bit active = 0, sent_end = 0, fin = 0;
    int k = 0;
    n_begin = 0; n_end = 0; n_we = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clock);
      data_valid_in = 1'b0; end_transaction_in = 1'b0; error_in = 1'b0; address_data_in = '0;
      if (active) begin
        if (k < nwords) begin
          data_valid_in = 1'b1; address_data_in = base + 32'(k); k++;
        end else if (!sent_end) begin
          end_transaction_in = 1'b1; sent_end = 1;
        end
      end
      #1;
      if (!busy_out) fin = 1;
      else begin
        if (begin_transaction_out) begin
          n_begin++; b_addr = address_data_out; b_burst = burst_size_out;
          b_rnw = read_n_write_out; b_be = byte_enables_out; active = 1;
        end
        if (buffer_write_enable_out) n_we++;
        if (end_transaction_out) n_end++;
      end
    end
    n_checks++;
    if (!fin) begin
      n_errors++;
      $display("FAIL read_complete: busy_out=%b expected 0 within 200 cycles", busy_out);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start_toggle_in = 1'b0; read_not_write_in = 1'b0; address_in = '0; burst_size_in = '0;
    byte_enables_in = '0; grant_in = 1'b1; address_data_in = '0; data_valid_in = 1'b0;
    busy_in = 1'b0; end_transaction_in = 1'b0; error_in = 1'b0; pre_we = 1'b0;
    pre_addr = '0; pre_data = '0; exp_done = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if ({busy_out, error_out, done_toggle_out, request_out, begin_transaction_out, data_valid_out,
         end_transaction_out, buffer_write_enable_out} !== 8'h00 || address_data_out !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: ctrl=%b%b%b%b%b%b%b%b data=%h expected all 0", busy_out, error_out,
               done_toggle_out, request_out, begin_transaction_out, data_valid_out, end_transaction_out,
               buffer_write_enable_out, address_data_out);
    end
    @(negedge clock); reset = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    n_checks++;
    if (busy_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: busy_out=%b expected 0", busy_out);
    end
  endtask

  task automatic test_write_basic;
    preload(0, WA); preload(1, WB); preload(2, WC);
    launch(1'b0, 32'h5555_5555, 8'd2, 4'hF);
    run_write(-1, 0, -1);
    exp_done = ~exp_done;
    n_checks++;
    if (n_begin !== 1 || b_addr !== 32'h5555_5555 || b_burst !== 8'd2 || b_rnw !== 1'b0 || b_be !== 4'hF) begin
      n_errors++;
      $display("FAIL write_begin: n=%0d addr=%h burst=%0d rnw=%b be=%h expected 1/55555555/2/0/f",
               n_begin, b_addr, b_burst, b_rnw, b_be);
    end
    n_checks++;
    if (q_words.size() != 3 || q_words[0] !== WA || q_words[1] !== WB || q_words[2] !== WC) begin
      n_errors++;
      $display("FAIL write_words: got %0d words expected A,B,C", q_words.size());
    end
    n_checks++;
    if (last_acc - first_acc != 2 || n_valid != 3) begin
      n_errors++;
      $display("FAIL write_no_bubble: span=%0d valid=%0d expected 2/3", last_acc - first_acc, n_valid);
    end
    n_checks++;
    if (n_end !== 1 || done_toggle_out !== exp_done || error_out !== 1'b0) begin
      n_errors++;
      $display("FAIL write_end: ends=%0d done=%b err=%b expected 1/%b/0", n_end, done_toggle_out, error_out, exp_done);
    end
  endtask

  task automatic test_write_stall;
    launch(1'b0, 32'h0000_1000, 8'd2, 4'b0101);
    run_write(1, 2, -1);
    exp_done = ~exp_done;
    n_checks++;
    if (b_be !== 4'b0101) begin
      n_errors++;
      $display("FAIL stall_be: be=%b expected 0101", b_be);
    end
    n_checks++;
    if (q_words.size() != 3 || q_words[0] !== WA || q_words[1] !== WB || q_words[2] !== WC || n_valid != 5) begin
      n_errors++;
      $display("FAIL stall_words: got %0d words in %0d valid cycles expected 3 in 5", q_words.size(), n_valid);
    end
    n_checks++;
    if (q_stall.size() != 2 || q_stall[0] !== WB || q_stall[1] !== WB) begin
      n_errors++;
      $display("FAIL stall_hold: %0d stalled cycles expected 2 holding %h", q_stall.size(), WB);
    end
  endtask

  task automatic test_read;
    for (int i = 0; i < 4; i++) preload(i, 32'hDEAD_0000 + 32'(i));
    launch(1'b1, 32'h2000_0040, 8'd3, 4'hF);
    run_read(4, 32'h1000_0000);
    exp_done = ~exp_done;
    n_checks++;
    if (n_begin !== 1 || b_rnw !== 1'b1 || b_burst !== 8'd3 || b_addr !== 32'h2000_0040) begin
      n_errors++;
      $display("FAIL read_begin: n=%0d rnw=%b burst=%0d addr=%h expected 1/1/3/20000040", n_begin, b_rnw, b_burst, b_addr);
    end
    n_checks++;
    if (mem[0] !== 32'h1000_0000 || mem[1] !== 32'h1000_0001 || mem[2] !== 32'h1000_0002 ||
        mem[3] !== 32'h1000_0003 || n_we != 4) begin
      n_errors++;
      $display("FAIL read_data: mem0..3=%h %h %h %h writes=%0d expected 10000000..3 / 4",
               mem[0], mem[1], mem[2], mem[3], n_we);
    end
    n_checks++;
    if (error_out !== 1'b0 || n_end != 0 || done_toggle_out !== exp_done) begin
      n_errors++;
      $display("FAIL read_end: err=%b ends=%0d done=%b expected 0/0/%b", error_out, n_end, done_toggle_out, exp_done);
    end
  endtask

  task automatic test_read_overflow;
    for (int i = 0; i < 4; i++) preload(i, 32'hDEAD_0000 + 32'(i));
    launch(1'b1, 32'h0, 8'd1, 4'hF);
    run_read(3, 32'h2000_0000);
    exp_done = ~exp_done;
    n_checks++;
    if (mem[0] !== 32'h2000_0000 || mem[1] !== 32'h2000_0001 || mem[2] !== 32'hDEAD_0002 || n_we != 2) begin
      n_errors++;
      $display("FAIL read_drop: mem0..2=%h %h %h writes=%0d expected 20000000 20000001 dead0002 / 2",
               mem[0], mem[1], mem[2], n_we);
    end
  endtask

  task automatic test_burst_clamp;
    launch(1'b1, 32'h0, 8'hFF, 4'hF);
    run_read(0, 32'h0);
    exp_done = ~exp_done;
    n_checks++;
    if (b_burst !== 8'd31) begin
      n_errors++;
      $display("FAIL burst_clamp: burst=%0d expected 31", b_burst);
    end
  endtask

  task automatic test_error;
    preload(0, WA); preload(1, WB); preload(2, WC);
    launch(1'b0, 32'h0000_2000, 8'd2, 4'hF);
    run_write(-1, 0, 1);
    exp_done = ~exp_done;
    n_checks++;
    if (error_out !== 1'b1 || n_end != 1 || q_words.size() != 1 || done_toggle_out !== exp_done) begin
      n_errors++;
      $display("FAIL error_abort: err=%b ends=%0d words=%0d done=%b expected 1/1/1/%b",
               error_out, n_end, q_words.size(), done_toggle_out, exp_done);
    end
    launch(1'b0, 32'h0000_3000, 8'd0, 4'hF);
    n_checks++;
    if (error_out !== 1'b0) begin
      n_errors++;
      $display("FAIL error_clear: err=%b expected 0", error_out);
    end
    run_write(-1, 0, -1);
    exp_done = ~exp_done;
  endtask

  task automatic test_toggle_while_busy;
    int begins = 0;
    bit idle = 0;
    bit late_busy = 0;
    grant_in = 1'b0;
    launch(1'b0, 32'h0000_4000, 8'd0, 4'hF);
    @(negedge clock); start_toggle_in = ~start_toggle_in;
`ifdef JTAG_DMA_TIMEOUT_EN
    for (int i = 0; i < 1200 && !idle; i++) begin
      @(negedge clock); #1;
      if (begin_transaction_out) begins++;
      if (!busy_out) idle = 1;
    end
    exp_done = ~exp_done;
    n_checks++;
    if (!idle || error_out !== 1'b1 || begins != 0 || done_toggle_out !== exp_done) begin
      n_errors++;
      $display("FAIL grant_timeout: idle=%b err=%b begins=%0d done=%b expected 1/1/0/%b",
               idle, error_out, begins, done_toggle_out, exp_done);
    end
    grant_in = 1'b1;
`else
    repeat (50) begin
      @(negedge clock); #1;
      if (begin_transaction_out) begins++;
    end
    n_checks++;
    if (request_out !== 1'b1 || error_out !== 1'b0 || begins != 0) begin
      n_errors++;
      $display("FAIL grant_wait: req=%b err=%b begins=%0d expected 1/0/0", request_out, error_out, begins);
    end
    grant_in = 1'b1;
    run_write(-1, 0, -1);
    exp_done = ~exp_done;
    n_checks++;
    if (n_begin != 1 || q_words.size() != 1) begin
      n_errors++;
      $display("FAIL single_launch: begins=%0d words=%0d expected 1/1", n_begin, q_words.size());
    end
`endif
    repeat (10) begin
      @(negedge clock); #1;
      if (busy_out) late_busy = 1;
    end
    n_checks++;
    if (late_busy) begin
      n_errors++;
      $display("FAIL no_replay: busy_out rose again=%b expected 0", late_busy);
    end
  endtask

  task automatic test_reset_mid;
    bit in_write = 0;
    for (int i = 0; i < 8; i++) preload(i, 32'hC000_0000 + 32'(i));
    launch(1'b0, 32'h0000_5000, 8'd7, 4'hF);
    for (int i = 0; i < 20 && !in_write; i++) begin
      @(negedge clock); #1;
      if (data_valid_out) in_write = 1;
    end
    @(negedge clock);
    reset = 1'b1; start_toggle_in = 1'b0;
    exp_done = 1'b0;
    #1;
    n_checks++;
    if (!in_write || {busy_out, error_out, done_toggle_out, request_out, begin_transaction_out, data_valid_out,
         end_transaction_out, buffer_write_enable_out} !== 8'h00 || address_data_out !== 32'h0 ||
        buffer_address_out !== 5'h0) begin
      n_errors++;
      $display("FAIL reset_mid: inwrite=%b busy=%b dv=%b end=%b done=%b data=%h expected 1/0/0/0/0/0",
               in_write, busy_out, data_valid_out, end_transaction_out, done_toggle_out, address_data_out);
    end
    @(negedge clock); reset = 1'b0;
    repeat (5) @(negedge clock);
    launch(1'b0, 32'h0000_6000, 8'd2, 4'hF);
    run_write(-1, 0, -1);
    exp_done = ~exp_done;
    n_checks++;
    if (q_words.size() != 3 || q_words[0] !== 32'hC000_0000 || q_words[1] !== 32'hC000_0001 ||
        q_words[2] !== 32'hC000_0002 || n_end != 1 || done_toggle_out !== exp_done) begin
      n_errors++;
      $display("FAIL reset_relaunch: words=%0d ends=%0d done=%b expected 3 from word 0 / 1 / %b",
               q_words.size(), n_end, done_toggle_out, exp_done);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_stall();
    test_read();
    test_read_overflow();
    test_burst_clamp();
    test_error();
    test_toggle_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete in 1 ms");
    $fatal(1);
  end

endmodule
`default_nettype wire
